player_ctrl: RTL

Game-level sequencer for the player ship, clocked by the frame clock. It owns the life cycle (idle, alive, explode, respawn, game over), the lives count and respawn invulnerability. It gates keyboard movement toward the `player` motion block and schedules the single player missile: launch, flight, termination and cooldown. It sits between the USB keycode source and the `player` motion block, the collision logic and the sprite renderer.

---
 rtl/player_ctrl_if.sv | 29 ++
 rtl/player_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl_if.sv
// Signal bundle between the player sequencer and its neighbours (keyboard, motion, collision, renderer).
// The master drives the game inputs; player_ctrl sits on the slave side.
interface player_ctrl_if;
  logic [7:0] keycode;
  logic [9:0] player_x;
  logic       player_hit;
  logic       missile_hit;
  logic [7:0] move_keycode;
  logic       player_respawn;
  logic       player_visible;
  logic       player_exploding;
  logic [2:0] lives;
  logic       game_over;
  logic       missile_active;
  logic [9:0] missile_x;
  logic [9:0] missile_y;

  modport master (
    output keycode, player_x, player_hit, missile_hit,
    input  move_keycode, player_respawn, player_visible, player_exploding,
           lives, game_over, missile_active, missile_x, missile_y
  );

  modport slave (
    input  keycode, player_x, player_hit, missile_hit,
    output move_keycode, player_respawn, player_visible, player_exploding,
           lives, game_over, missile_active, missile_x, missile_y
  );
endinterface

// File: rtl/player_ctrl.sv
// Player ship sequencer: life cycle, lives, respawn invulnerability, movement gating
// and the single player missile, all stepped once per video frame.
module player_ctrl #(
  parameter int LIVES_INIT      = 3,
  parameter int EXPLODE_FRAMES  = 32,
  parameter int RESPAWN_FRAMES  = 60,
  parameter int INVULN_FRAMES   = 90,
  parameter int MISSILE_STEP    = 8,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int PLAYER_Y        = 440
) (
  input  logic         frame_clk,
  input  logic         Reset_n,
  player_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ALIVE     = 3'd1;
  localparam logic [2:0] ST_EXPLODE   = 3'd2;
  localparam logic [2:0] ST_RESPAWN   = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  localparam logic [7:0] KEY_START     = 8'h28;
  localparam logic [7:0] KEY_FIRE      = 8'h2C;
  localparam logic [2:0] LIVES_LOAD    = 3'(LIVES_INIT);
  localparam logic [7:0] EXPLODE_LAST  = 8'(EXPLODE_FRAMES - 1);
  localparam logic [7:0] RESPAWN_LAST  = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] INVULN_LOAD   = 8'(INVULN_FRAMES);
  localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES);
  localparam logic [9:0] STEP_Y        = 10'(MISSILE_STEP);
  localparam logic [9:0] LAUNCH_Y      = 10'(PLAYER_Y - MISSILE_STEP);

  function automatic logic is_move_key(input logic [7:0] k);
    case (k)
      8'h04, 8'h07, 8'h4F, 8'h50: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  logic [2:0] state_r, state_s;
  logic [2:0] lives_r, lives_s;
  logic [7:0] timer_r, timer_s;
  logic [7:0] invuln_r, invuln_s;
  logic [7:0] cooldown_r, cooldown_s;
  logic       start_prev_r, fire_prev_r, start_armed_r;
  logic       m_active_r, m_active_s;
  logic [9:0] m_x_r, m_x_s, m_y_r, m_y_s;
  logic [7:0] move_kc_r, move_kc_s;
  logic       respawn_r, respawn_s;
  logic       visible_r, visible_s;
  logic       exploding_r, exploding_s;
  logic       game_over_r, game_over_s;
  logic       clear_s;
  logic       start_ev_s, fire_ev_s;

  // Start only arms once the start key has been seen released, so a key held through reset cannot start a game.
  assign start_ev_s = (bus.keycode == KEY_START) && !start_prev_r && start_armed_r;
  assign fire_ev_s  = (bus.keycode == KEY_FIRE) && !fire_prev_r;

  // Life-cycle next state, lives, phase timer and invulnerability.
  always_comb begin
    state_s   = state_r;
    lives_s   = lives_r;
    timer_s   = timer_r;
    invuln_s  = invuln_r;
    respawn_s = 1'b0;
    clear_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_ev_s) begin
          state_s   = ST_ALIVE;
          lives_s   = LIVES_LOAD;
          invuln_s  = INVULN_LOAD;
          respawn_s = 1'b1;
          clear_s   = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_ALIVE: begin
        invuln_s = (invuln_r != 8'd0) ? invuln_r - 8'd1 : 8'd0;
        if (bus.player_hit && (invuln_r == 8'd0)) begin
          state_s = ST_EXPLODE;
          lives_s = lives_r - 3'd1;
          timer_s = EXPLODE_LAST;
        end else begin
          state_s = ST_ALIVE;
        end
      end
      ST_EXPLODE: begin
        if (timer_r != 8'd0) begin
          timer_s = timer_r - 8'd1;
        end else if (lives_r == 3'd0) begin
          state_s = ST_GAME_OVER;
        end else begin
          state_s = ST_RESPAWN;
          timer_s = RESPAWN_LAST;
        end
      end
      ST_RESPAWN: begin
        if (timer_r != 8'd0) begin
          timer_s = timer_r - 8'd1;
        end else begin
          state_s   = ST_ALIVE;
          invuln_s  = INVULN_LOAD;
          respawn_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Missile launch, flight and cooldown; it flies on through EXPLODE/RESPAWN until it ends by itself.
  always_comb begin
    m_active_s = m_active_r;
    m_x_s      = m_x_r;
    m_y_s      = m_y_r;
    cooldown_s = (cooldown_r != 8'd0) ? cooldown_r - 8'd1 : 8'd0;
    if (clear_s) begin
      m_active_s = 1'b0;
      m_x_s      = 10'd0;
      m_y_s      = 10'd0;
      cooldown_s = 8'd0;
    end else if (m_active_r) begin
      if (bus.missile_hit || (m_y_r < STEP_Y)) begin
        m_active_s = 1'b0;
        cooldown_s = COOLDOWN_LOAD;
      end else begin
        m_y_s = m_y_r - STEP_Y;
      end
    end else if (fire_ev_s && (state_r == ST_ALIVE) && (cooldown_r == 8'd0)) begin
      m_active_s = 1'b1;
      m_x_s      = bus.player_x;
      m_y_s      = LAUNCH_Y;
    end else begin
      m_active_s = 1'b0;
    end
  end

  // Output decode from the post-edge state so outputs change on the edge that samples their cause.
  always_comb begin
    move_kc_s   = ((state_s == ST_ALIVE) && is_move_key(bus.keycode)) ? bus.keycode : 8'd0;
    visible_s   = (state_s == ST_ALIVE) && ((invuln_s == 8'd0) || invuln_s[3]);
    exploding_s = (state_s == ST_EXPLODE);
    game_over_s = (state_s == ST_GAME_OVER);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_r       <= ST_IDLE;
      lives_r       <= 3'd0;
      timer_r       <= 8'd0;
      invuln_r      <= 8'd0;
      cooldown_r    <= 8'd0;
      start_prev_r  <= 1'b0;
      fire_prev_r   <= 1'b0;
      start_armed_r <= (bus.keycode != KEY_START);
      m_active_r    <= 1'b0;
      m_x_r         <= 10'd0;
      m_y_r         <= 10'd0;
      move_kc_r     <= 8'd0;
      respawn_r     <= 1'b0;
      visible_r     <= 1'b0;
      exploding_r   <= 1'b0;
      game_over_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      lives_r       <= lives_s;
      timer_r       <= timer_s;
      invuln_r      <= invuln_s;
      cooldown_r    <= cooldown_s;
      start_prev_r  <= (bus.keycode == KEY_START);
      fire_prev_r   <= (bus.keycode == KEY_FIRE);
      start_armed_r <= start_armed_r | (bus.keycode != KEY_START);
      m_active_r    <= m_active_s;
      m_x_r         <= m_x_s;
      m_y_r         <= m_y_s;
      move_kc_r     <= move_kc_s;
      respawn_r     <= respawn_s;
      visible_r     <= visible_s;
      exploding_r   <= exploding_s;
      game_over_r   <= game_over_s;
    end
  end

  assign bus.move_keycode     = move_kc_r;
  assign bus.player_respawn   = respawn_r;
  assign bus.player_visible   = visible_r;
  assign bus.player_exploding = exploding_r;
  assign bus.lives            = lives_r;
  assign bus.game_over        = game_over_r;
  assign bus.missile_active   = m_active_r;
  assign bus.missile_x        = m_x_r;
  assign bus.missile_y        = m_y_r;

endmodule
